// File: rtl/p405s_timer_pkg.sv
// Shared definitions for the time-base read path.
// Holds the FSM encoding and the time-base width.
package p405s_timer_pkg;

    localparam int TB_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } tb_rd_state_e;

endpackage

// File: rtl/p405s_timer_tb_shadow.sv
// TBU shadow register plus its coherence flag.
// Clear beats capture so a write to the time base never leaves a stale upper half.
module p405s_timer_tb_shadow
    import p405s_timer_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cap_i,
    input  logic            consume_i,
    input  logic            clr_i,
    input  logic [TB_W-1:0] tbh_i,
    output logic [TB_W-1:0] data_o,
    output logic            valid_o
);

    logic [TB_W-1:0] data_q, data_d;
    logic            valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (cap_i) begin
            data_d  = tbh_i;
            valid_d = 1'b1;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/p405s_timer_tb_read.sv
// mfSPR read port for TBU/TBL with a coherent upper-half shadow.
// One-cycle read latency; output frozen while the pipe holds.
module p405s_timer_tb_read
    import p405s_timer_pkg::*;
(
    input  logic            CB,
    input  logic            rstNEG,
    input  logic [TB_W-1:0] tbhL2,
    input  logic [TB_W-1:0] tblL2,
    input  logic            PCL_mfSPR,
    input  logic            PCL_mtSPR,
    input  logic            PCL_sprHold,
    input  logic            tbhDcd,
    input  logic            tblDcd,
    output logic [TB_W-1:0] TMR_sprDataBus,
    output logic            TMR_sprDataValid,
    output logic            TMR_tbShadowValid
);

    tb_rd_state_e    state_q, state_d;
    logic [TB_W-1:0] data_q, data_d;
    logic            valid_q, valid_d;

    logic            tb_hit;
    logic            accept;
    logic            mt_clr;
    logic            sh_cap;
    logic            sh_consume;
    logic [TB_W-1:0] sh_data;
    logic            sh_valid;

    assign tb_hit     = tbhDcd | tblDcd;
    assign accept     = (state_q == IDLE) & PCL_mfSPR
                      & tb_hit & ~PCL_sprHold;
    assign mt_clr     = PCL_mtSPR & tb_hit & ~PCL_sprHold;
    assign sh_cap     = accept & tblDcd;
    assign sh_consume = accept & ~tblDcd & sh_valid;

    p405s_timer_tb_shadow u_shadow (
        .clk_i     (CB),
        .rst_ni    (rstNEG),
        .cap_i     (sh_cap),
        .consume_i (sh_consume),
        .clr_i     (mt_clr),
        .tbh_i     (tbhL2),
        .data_o    (sh_data),
        .valid_o   (sh_valid)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DRIVE;
                    valid_d = 1'b1;
                    if (tblDcd) begin
                        data_d = tblL2;
                    end else if (sh_valid) begin
                        data_d = sh_data;
                    end else begin
                        data_d = tbhL2;
                    end
                end
            end
            DRIVE: begin
                if (!PCL_sprHold) begin
                    state_d = IDLE;
                    data_d  = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CB) begin
        if (!rstNEG) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign TMR_sprDataBus    = data_q;
    assign TMR_sprDataValid  = valid_q;
    assign TMR_tbShadowValid = sh_valid;

endmodule

// File: tb/tb_p405s_timer_tb_read.sv
// Directed bench for the time-base read port.
// A read-level model is checked every cycle, plus literal spot checks.
module tb_p405s_timer_tb_read;

    logic        CB;
    logic        rstNEG;
    logic [31:0] tbhL2;
    logic [31:0] tblL2;
    logic        PCL_mfSPR;
    logic        PCL_mtSPR;
    logic        PCL_sprHold;
    logic        tbhDcd;
    logic        tblDcd;
    logic [31:0] TMR_sprDataBus;
    logic        TMR_sprDataValid;
    logic        TMR_tbShadowValid;

    int checks = 0;
    int errors = 0;

    p405s_timer_tb_read dut (
        .CB                (CB),
        .rstNEG            (rstNEG),
        .tbhL2             (tbhL2),
        .tblL2             (tblL2),
        .PCL_mfSPR         (PCL_mfSPR),
        .PCL_mtSPR         (PCL_mtSPR),
        .PCL_sprHold       (PCL_sprHold),
        .tbhDcd            (tbhDcd),
        .tblDcd            (tblDcd),
        .TMR_sprDataBus    (TMR_sprDataBus),
        .TMR_sprDataValid  (TMR_sprDataValid),
        .TMR_tbShadowValid (TMR_tbShadowValid)
    );

    initial CB = 1'b0;
    always #5 CB = ~CB;

    // Read-level model: a read in flight, its value, and the saved upper half.
    bit          m_busy;
    logic [31:0] m_data;
    logic [31:0] m_upper;
    bit          m_upper_ok;

    always @(posedge CB) begin
        bit hit;
        bit wr;
        hit = tbhDcd || tblDcd;
        wr  = PCL_mtSPR && hit && !PCL_sprHold;
        if (!rstNEG) begin
            m_busy     = 0;
            m_data     = 0;
            m_upper    = 0;
            m_upper_ok = 0;
        end else begin
            if (m_busy) begin
                if (!PCL_sprHold) begin
                    m_busy = 0;
                    m_data = 0;
                end
            end else if (PCL_mfSPR && hit && !PCL_sprHold) begin
                m_busy = 1;
                if (tblDcd) begin
                    m_data = tblL2;
                    if (!wr) begin
                        m_upper    = tbhL2;
                        m_upper_ok = 1;
                    end
                end else if (m_upper_ok) begin
                    m_data     = m_upper;
                    m_upper_ok = 0;
                end else begin
                    m_data = tbhL2;
                end
            end
            if (wr) m_upper_ok = 0;
        end
    end

    always @(negedge CB) begin
        checks++;
        if (TMR_sprDataValid !== m_busy ||
            TMR_sprDataBus !== m_data ||
            TMR_tbShadowValid !== m_upper_ok) begin
            errors++;
            $display("FAIL model t=%0t got v=%b d=%h s=%b want v=%b d=%h s=%b",
                     $time, TMR_sprDataValid, TMR_sprDataBus,
                     TMR_tbShadowValid, m_busy, m_data, m_upper_ok);
        end
    end

    task automatic step();
        @(posedge CB);
        #1;
    endtask

    task automatic quiet();
        PCL_mfSPR   = 0;
        PCL_mtSPR   = 0;
        PCL_sprHold = 0;
        tbhDcd      = 0;
        tblDcd      = 0;
    endtask

    task automatic chk(input string nm, input logic v,
                       input logic [31:0] d, input logic s);
        checks++;
        if (TMR_sprDataValid !== v || TMR_sprDataBus !== d ||
            TMR_tbShadowValid !== s) begin
            errors++;
            $display("FAIL %s got v=%b d=%h s=%b want v=%b d=%h s=%b",
                     nm, TMR_sprDataValid, TMR_sprDataBus,
                     TMR_tbShadowValid, v, d, s);
        end
    endtask

    task automatic rd(input bit hi, input bit lo);
        PCL_mfSPR = 1;
        tbhDcd    = hi;
        tblDcd    = lo;
        step();
        quiet();
    endtask

    initial begin
        rstNEG = 0;
        tbhL2  = 0;
        tblL2  = 0;
        quiet();
        step();
        step();
        chk("reset", 0, 32'h0, 0);
        rstNEG = 1;

        tbhL2 = 32'h2;
        tblL2 = 32'h10;
        rd(0, 1);
        chk("tbl_read", 1, 32'h10, 1);
        step();
        chk("tbl_done", 0, 32'h0, 1);

        tbhL2 = 32'h3;
        rd(1, 0);
        chk("tbu_shadow", 1, 32'h2, 0);
        step();
        rd(1, 0);
        chk("tbu_live", 1, 32'h3, 0);
        step();

        tbhL2 = 32'h1234_5678;
        rd(1, 0);
        PCL_sprHold = 1;
        tbhL2 = 32'h9999_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_stable", 1, 32'h1234_5678, 0);
        end
        PCL_sprHold = 0;
        step();
        chk("hold_release", 0, 32'h0, 0);

        tbhL2 = 32'h5;
        tblL2 = 32'hFFFF_FFFF;
        rd(0, 1);
        chk("tbl_allones", 1, 32'hFFFF_FFFF, 1);
        step();
        tblL2 = 32'h0;
        PCL_mtSPR = 1;
        tbhDcd    = 1;
        step();
        quiet();
        chk("mt_clear", 0, 32'h0, 0);
        tbhL2 = 32'h6;
        rd(1, 0);
        chk("tbu_after_mt", 1, 32'h6, 0);
        step();

        PCL_mfSPR   = 1;
        tblDcd      = 1;
        PCL_sprHold = 1;
        tblL2       = 32'hABCD_0000;
        step();
        chk("held_req0", 0, 32'h0, 0);
        step();
        chk("held_req1", 0, 32'h0, 0);
        PCL_sprHold = 0;
        step();
        quiet();
        chk("held_req_go", 1, 32'hABCD_0000, 1);
        step();

        PCL_mfSPR = 1;
        step();
        quiet();
        chk("no_decode", 0, 32'h0, 1);

        tblL2 = 32'h0;
        tbhL2 = 32'h7;
        PCL_mtSPR = 1;
        rd(0, 1);
        chk("clr_beats_cap", 1, 32'h0, 0);
        step();

        tbhL2 = 32'h8;
        tblL2 = 32'h11;
        rd(1, 1);
        chk("both_dcd", 1, 32'h11, 1);
        step();

        rd(1, 0);
        chk("tbu_shadow2", 1, 32'h8, 0);
        PCL_sprHold = 1;
        step();
        rstNEG    = 0;
        PCL_mfSPR = 1;
        tblDcd    = 1;
        step();
        chk("reset_drive", 0, 32'h0, 0);
        step();
        chk("reset_accept", 0, 32'h0, 0);
        rstNEG = 1;
        quiet();
        step();
        chk("post_reset", 0, 32'h0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p405s_timer_tb_read.md
P405S_TIMER_TB_READ -- requirements
Module: p405s_timer_tb_read

Interface
REQ-001 SHALL have port CB  input  1  sole clock; all state updates on posedge CB.
REQ-002 SHALL have port rstNEG  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port tbhL2  input  32  current time-base upper register, bits [0:31].
REQ-004 SHALL have port tblL2  input  32  current time-base lower register, bits [0:31].
REQ-005 SHALL have port PCL_mfSPR  input  1  move-from-SPR in progress.
REQ-006 SHALL have port PCL_mtSPR  input  1  move-to-SPR in progress.
REQ-007 SHALL have port PCL_sprHold  input  1  pipe hold; blocks acceptance and freezes output.
REQ-008 SHALL have port tbhDcd  input  1  SPR decode hit for TBU.
REQ-009 SHALL have port tblDcd  input  1  SPR decode hit for TBL.
REQ-010 SHALL have port TMR_sprDataBus  output  32  read data, bits [0:31]; all-zero when not valid.
REQ-011 SHALL have port TMR_sprDataValid  output  1  read data valid qualifier.
REQ-012 SHALL have port TMR_tbShadowValid  output  1  TBU shadow holds a coherent upper half.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE; encoding from the shared package.
REQ-014 SHALL define accept = IDLE & PCL_mfSPR & (tbhDcd | tblDcd) & ~PCL_sprHold.
REQ-015 SHALL, on accept, register the selected value and enter DRIVE; valid asserts exactly 1 cycle after accept.
REQ-016 SHALL, on accept with tblDcd, return tblL2 and capture tbhL2 of the same cycle into the TBU shadow, setting TMR_tbShadowValid.
REQ-017 SHALL, on accept with tbhDcd and shadow valid, return the shadow and clear shadow valid; with shadow invalid, return tbhL2.
REQ-018 SHALL, when tbhDcd and tblDcd are both set on accept, give tblDcd priority (TBL path, REQ-016).
REQ-019 SHALL hold TMR_sprDataBus and TMR_sprDataValid stable in DRIVE while PCL_sprHold = 1.
REQ-020 SHALL leave DRIVE for IDLE on the first cycle with PCL_sprHold = 0; valid deasserts the following cycle; no new accept in the DRIVE cycle.
REQ-021 SHALL clear shadow valid on any PCL_mtSPR & (tbhDcd | tblDcd) & ~PCL_sprHold, taking priority over a simultaneous capture.
REQ-022 SHALL ignore PCL_mfSPR without a TB decode hit; state and outputs unchanged.
REQ-023 SHALL pass data unmodified; no arithmetic on the time base; wrap 0xFFFFFFFF->0 in tblL2 is transparent.

Reset
REQ-024 SHALL, when rstNEG = 0 at posedge CB, force IDLE, TMR_sprDataBus = 0, TMR_sprDataValid = 0, shadow = 0, TMR_tbShadowValid = 0.
REQ-025 SHALL let reset abort a read in DRIVE mid-hold; no data delivered after reset.
REQ-026 SHALL let reset override accept, mtSPR clear and hold in the same cycle.

Structure
REQ-027 SHALL place FSM state encoding and the 32-bit TB width constant in shared package p405s_timer_pkg.
REQ-028 SHALL implement shadow register plus valid flag as one sub-module p405s_timer_tb_shadow (capture, consume, clear, reset).
REQ-029 SHALL be purely single-clock synchronous; no latches, no gated clocks.

Verification
REQ-030 SHALL cover: reset, then TBL read with tblL2=0x0000_0010, tbhL2=0x0000_0002 -> cycle+1 data=0x10, valid=1; TMR_tbShadowValid=1.
REQ-031 SHALL cover: after REQ-030, tbhL2 changes to 0x3 and TBU is read -> data=0x2 (shadow); shadow valid clears; next TBU read -> 0x3.
REQ-032 SHALL cover: TBU read accepted, PCL_sprHold=1 for 3 cycles -> data/valid stable 3 cycles; IDLE after hold drop; valid low one cycle later.
REQ-033 SHALL cover: TBL read then mtSPR to TBU (no hold) -> shadow valid clears; TBU read returns live tbhL2.
REQ-034 SHALL cover: mfSPR with PCL_sprHold=1 at request -> no accept, valid stays 0 until hold drops.
REQ-035 SHALL cover: rstNEG=0 during DRIVE with hold active -> next cycle data=0, valid=0, shadow valid=0, IDLE.
